// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide engine with its own HI/LO pair.
// Multiply is shift-add, divide is restoring, UNROLL bits per cycle on
// absolute values; a final FIX cycle applies the sign correction and
// commits HI/LO. mthi/mtlo writes and reads share the same register pair.
module muldiv_hilo_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             abort_i,
  input  logic             hilo_rd_i,
  input  logic             mt_we_i,
  input  logic             hilo_sel_i,
  input  logic [WIDTH-1:0] mt_data_i,
  output logic [WIDTH-1:0] hilo_out_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // One shift-add step: {hi,lo} with multiplier bits consumed from lo[0].
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: {rem,dividend/quotient}, quotient bit enters at lo[0].
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] rem;
    sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge  = (sh >= {1'b0, d});
    rem = ge ? (sh[WIDTH-1:0] - d) : sh[WIDTH-1:0];
    return {rem, acc[WIDTH-2:0], ge};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   b_q, a_orig_q;
  logic [1:0]         op_q;
  logic               neg_res_q, neg_rem_q, dbz_op_q;

  logic               idle, accept, signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign idle      = (state_q == S_IDLE);
  assign accept    = idle & start_i & ~abort_i;
  assign signed_op = ~op_i[0];
  assign a_abs     = (signed_op & src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign b_abs     = (signed_op & src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

  // Advance the datapath by UNROLL multiply or divide steps.
  always_comb begin
    acc_step = acc_q;
    for (int k = 0; k < UNROLL; k++) begin
      acc_step = op_q[1] ? div_step(acc_step, b_q) : mul_step(acc_step, b_q);
    end
  end

  // Sign correction and divide-by-zero override for the FIX cycle.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      fix_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (dbz_op_q) begin
        fix_hi = a_orig_q;
        fix_lo = {WIDTH{1'b1}};
      end
    end
  end

  // Control FSM, HI/LO commit and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (mt_we_i) begin
          if (hilo_sel_i) lo_d = mt_data_i;
          else            hi_d = mt_data_i;
        end
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
          dz_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        dz_d    = dbz_op_q;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush drops the in-flight op without touching architectural state.
    if (abort_i && !idle) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
    end
  end

  // Control and architectural registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Operand latch on accept and iterative accumulator update.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q      <= op_i;
      acc_q     <= {{WIDTH{1'b0}}, a_abs};
      b_q       <= b_abs;
      a_orig_q  <= src_a_i;
      neg_res_q <= signed_op & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
      neg_rem_q <= signed_op & src_a_i[WIDTH-1];
      dbz_op_q  <= op_i[1] & (src_b_i == '0);
    end else if (state_q == S_RUN) begin
      acc_q <= acc_step;
    end
  end

  assign busy_o        = ~idle;
  assign stall_o       = busy_o & (start_i | hilo_rd_i | mt_we_i);
  assign hilo_out_o    = hilo_sel_i ? lo_q : hi_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit (WIDTH=32, UNROLL=1).
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         clk, rst;
  logic         start_i, abort_i, hilo_rd_i, mt_we_i, hilo_sel_i;
  logic [1:0]   op_i;
  logic [W-1:0] src_a_i, src_b_i, mt_data_i;
  logic [W-1:0] hilo_out_o;
  logic         busy_o, stall_o, done_o, div_by_zero_o;

  muldiv_hilo_unit #(.WIDTH(W), .UNROLL(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .abort_i(abort_i),
    .hilo_rd_i(hilo_rd_i), .mt_we_i(mt_we_i), .hilo_sel_i(hilo_sel_i),
    .mt_data_i(mt_data_i), .hilo_out_o(hilo_out_o), .busy_o(busy_o),
    .stall_o(stall_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        scb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_hi = 0, model_lo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS HI/LO semantics.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, p, q, r;
    logic [63:0] v, qv, rv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dbz = 1'b0;
    case (op)
      2'b00: begin p = sa * sbv; v = p; e.hi = v[63:32]; e.lo = v[31:0]; end
      2'b01: begin v = {32'd0, a} * {32'd0, b}; e.hi = v[63:32]; e.lo = v[31:0]; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sbv; r = sa % sbv; qv = q; rv = r;
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on each done pulse and checks LO, flag,
  // busy length, then HI on the following cycle.
  int          busy_cnt = 0;
  logic        pend_hi = 0;
  logic [31:0] pend_val = 0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      pend_hi  = 0;
    end else begin
      if (pend_hi) begin
        chk("result_hi", hilo_out_o, pend_val);
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
        pend_hi = 0;
      end
      if (busy_o) busy_cnt++;
      else begin
        if (done_o) begin
          if (scb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            mon_e = scb.pop_front();
            chk("result_lo", hilo_out_o, mon_e.lo);
            chk("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, mon_e.dbz});
            chk("busy_cycles", busy_cnt, 33);
            pend_hi  = 1;
            pend_val = mon_e.hi;
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // mode 0 normal, 1 stall probes mid-run, 2 abort in cycle 10, 3 mt write with start
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    int   cyc;
    e = model(op, a, b);
    op_i = op; src_a_i = a; src_b_i = b; start_i = 1; hilo_sel_i = 1;
    if (mode == 3) begin mt_we_i = 1; mt_data_i = 32'h0BADF00D; end
    if (mode != 2) scb.push_back(e);
    @(posedge clk); #1;
    start_i = 0; mt_we_i = 0;
    chk("dbz_cleared_on_start", {31'd0, div_by_zero_o}, 32'd0);
    if (mode == 3) chk("mt_with_start", hilo_out_o, 32'h0BADF00D);
    for (cyc = 1; cyc < 60; cyc++) begin
      if (mode == 1) begin
        hilo_rd_i = (cyc >= 5);
        start_i   = (cyc == 10);
        mt_we_i   = (cyc == 12);
        mt_data_i = 32'hDEADBEEF;
        #1;
        if (cyc >= 5 && cyc <= 33) chk("stall_busy", {31'd0, stall_o}, 32'd1);
        if (cyc == 34) chk("stall_released", {31'd0, stall_o}, 32'd0);
        start_i = 0; mt_we_i = 0;
      end
      if (mode == 2) begin
        abort_i = (cyc == 10);
        if (cyc == 11) begin
          chk("abort_busy", {31'd0, busy_o}, 32'd0);
          chk("abort_done", {31'd0, done_o}, 32'd0);
          break;
        end
      end
      if (done_o) break;
      @(posedge clk); #1;
    end
    hilo_rd_i = 0;
    if (mode == 2) begin
      chk("abort_keeps_lo", hilo_out_o, model_lo);
      hilo_sel_i = 0; #1;
      chk("abort_keeps_hi", hilo_out_o, model_hi);
      hilo_sel_i = 1;
      @(posedge clk); #1;
    end else begin
      vectors++;
      if (cyc != 34) begin
        miscompares++;
        $display("FAIL done_cycle: got %0d expected 34", cyc);
      end
      model_hi = e.hi; model_lo = e.lo;
      @(negedge clk); #1;
      hilo_sel_i = 0;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1; start_i = 0; abort_i = 0; hilo_rd_i = 0; mt_we_i = 0;
    hilo_sel_i = 0; op_i = 0; src_a_i = 0; src_b_i = 0; mt_data_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    chk("rst_hi", hilo_out_o, 32'd0);
    hilo_sel_i = 1; hilo_rd_i = 1; #1;
    chk("rst_lo", hilo_out_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    hilo_rd_i = 0;
    rst = 0;
    @(posedge clk); #1;

    // mthi / mtlo in IDLE
    mt_we_i = 1; hilo_sel_i = 0; mt_data_i = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mt_we_i = 0;
    chk("mthi", hilo_out_o, 32'hA5A5A5A5);
    chk("mt_idle_stall", {31'd0, stall_o}, 32'd0);
    mt_we_i = 1; hilo_sel_i = 1; mt_data_i = 32'h5A5A1234;
    @(posedge clk); #1;
    mt_we_i = 0;
    chk("mtlo", hilo_out_o, 32'h5A5A1234);
    model_hi = 32'hA5A5A5A5; model_lo = 32'h5A5A1234;

    // abort with nonzero HI/LO, then a fresh multu
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 2);
    run_op(2'b01, 32'd6, 32'd7, 0);

    // directed corner cases
    run_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 0);
    run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0);
    run_op(2'b11, 32'd7, 32'd2, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b11, 32'h00001234, 32'd0, 0);
    run_op(2'b10, 32'hFFFFFF00, 32'd0, 0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 0);
    run_op(2'b00, 32'hFFFF0001, 32'h00001234, 1);
    run_op(2'b11, 32'd100, 32'd9, 3);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0);
    end

    // asynchronous reset mid-run
    op_i = 2'b00; src_a_i = 32'h7FFFFFFF; src_b_i = 32'h00000005; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    repeat (8) @(posedge clk);
    #2;
    hilo_rd_i = 1; hilo_sel_i = 0;
    rst = 1;
    #1;
    chk("async_busy", {31'd0, busy_o}, 32'd0);
    chk("async_stall", {31'd0, stall_o}, 32'd0);
    chk("async_done", {31'd0, done_o}, 32'd0);
    chk("async_hi", hilo_out_o, 32'd0);
    hilo_sel_i = 1; #1;
    chk("async_lo", hilo_out_o, 32'd0);
    hilo_rd_i = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", scb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
